// File: rtl/data_stack.sv
// -----------------------------------------------------------------------------
// data_stack
//
// Register-file data stack for the stack-machine CPU datapath. The stack holds
// DEPTH words of WIDTH bits. Entry 0 is the top of stack and entry DEPTH-1 is
// the bottom. A push shifts every entry one slot deeper and a pop shifts every
// entry one slot shallower, so the top two entries and the bottom entry always
// sit at fixed register locations. The ALU uses sr0/sr1 directly, and the
// spill/fill logic uses the bottom entry.
//
// Optional feature (macro DS_UNDERFLOW_EN):
//   When defined, the design adds the sticky stack_underflow output. It is set
//   by a pop-only cycle on an empty stack. When undefined, that port and its
//   logic are absent, and a pop on empty is silently ignored.
//
// Parameters:
//   WIDTH  bits per stack entry (default 16)
//   DEPTH  number of entries (default 128, must be >= 2). The sr127_* ports
//          always refer to entry DEPTH-1, whatever DEPTH is.
//
// Ports:
//   clk             rising-edge clock
//   async_reset     asynchronous, active-low reset
//   sr0_in          data for top of stack (push with data_write, or overwrite)
//   sr1_in          data forced into sr1 when sr1_overwrite=1
//   sr127_in        fill data entering the bottom entry on a pop
//   sr1_overwrite   sr1 <= sr1_in this cycle, with final priority
//   data_write      load sr0 from sr0_in (ignored on pop-only cycles)
//   data_read       read strobe; no effect on state
//   push            shift stack down one slot
//   pop             shift stack up one slot
//   sr0_out         current top entry
//   sr1_out         current second entry
//   sr127_out       current bottom entry (spill data, lost on overflow)
//   ds_size         number of valid entries, 0..DEPTH, zero-extended to 16 bits
//   stack_overflow  sticky, set by a push while full
//   stack_underflow sticky, set by a pop while empty (DS_UNDERFLOW_EN only)
//
// Control strobes are level-sampled on each rising clk edge. There is no
// handshake, and the outputs come straight from registers, so they are always
// valid. Each command takes exactly one edge.
// -----------------------------------------------------------------------------
module data_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 128
) (
  input  logic             clk,
  input  logic             async_reset,
  input  logic [WIDTH-1:0] sr0_in,
  input  logic [WIDTH-1:0] sr1_in,
  input  logic [WIDTH-1:0] sr127_in,
  input  logic             sr1_overwrite,
  input  logic             data_write,
  input  logic             data_read,
  input  logic             push,
  input  logic             pop,
  output logic [WIDTH-1:0] sr0_out,
  output logic [WIDTH-1:0] sr1_out,
  output logic [WIDTH-1:0] sr127_out,
  output logic [15:0]      ds_size,
`ifdef DS_UNDERFLOW_EN
  output logic             stack_underflow,
`endif
  output logic             stack_overflow
);

  // The count must be able to represent DEPTH itself, not only DEPTH-1.
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] sr     [DEPTH];
  logic [WIDTH-1:0] sr_nxt [DEPTH];
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             overflow_nxt;

  // data_read is an observation strobe only. All outputs are always valid.
  logic unused_data_read;
  assign unused_data_read = data_read;

  // Command decode. Push and pop together cancel the shift, and the cycle
  // behaves like a plain top-of-stack write.
  logic push_only;
  logic pop_only;
  logic pop_shift;
  logic is_full;
  logic is_empty;

  assign push_only = push & ~pop;
  assign pop_only  = pop & ~push;
  assign is_full   = (count == FULL);
  assign is_empty  = (count == '0);
  assign pop_shift = pop_only & ~is_empty;

  // ---------------------------------------------------------------------------
  // Next-state for the entry array.
  // ---------------------------------------------------------------------------
  always_comb begin
    sr_nxt = sr;
    if (push_only) begin
      // The deepest entry falls off the bottom. That entry is lost on overflow.
      for (int k = 1; k < DEPTH; k++) begin
        sr_nxt[k] = sr[k-1];
      end
      // Without data_write, sr0 keeps its value, which duplicates the top.
      if (data_write) begin
        sr_nxt[0] = sr0_in;
      end
    end else if (pop_shift) begin
      for (int k = 0; k < DEPTH - 1; k++) begin
        sr_nxt[k] = sr[k+1];
      end
      sr_nxt[DEPTH-1] = sr127_in;
    end else if (!pop_only && data_write) begin
      // This covers idle+write (overwrite top) and push+pop+write
      // (replace top). A pop-only cycle never writes, even on an empty stack.
      sr_nxt[0] = sr0_in;
    end

    // The sr1 override wins over any shift or hold result for entry 1.
    if (sr1_overwrite) begin
      sr_nxt[1] = sr1_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state for the occupancy count and the overflow flag.
  // ---------------------------------------------------------------------------
  always_comb begin
    count_nxt    = count;
    overflow_nxt = stack_overflow;
    if (push_only) begin
      if (is_full) begin
        overflow_nxt = 1'b1;
      end else begin
        count_nxt = count + 1'b1;
      end
    end else if (pop_shift) begin
      count_nxt = count - 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        sr[k] <= '0;
      end
      count          <= '0;
      stack_overflow <= 1'b0;
    end else begin
      sr             <= sr_nxt;
      count          <= count_nxt;
      stack_overflow <= overflow_nxt;
    end
  end

`ifdef DS_UNDERFLOW_EN
  // This flag is sticky until reset. Only a pop-only cycle on an empty stack
  // sets it. Push+pop on an empty stack is a replace-top, not an underflow.
  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      stack_underflow <= 1'b0;
    end else if (pop_only && is_empty) begin
      stack_underflow <= 1'b1;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign sr0_out   = sr[0];
  assign sr1_out   = sr[1];
  assign sr127_out = sr[DEPTH-1];
  assign ds_size   = 16'(count);

endmodule

// File: tb/tb_data_stack.sv
module tb_data_stack;

  localparam int WIDTH = 16;
  localparam int DEPTH = 128;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic async_reset = 1'b0;
  always #5 clk = ~clk;

  logic [WIDTH-1:0] sr0_in, sr1_in, sr127_in;
  logic             sr1_overwrite, data_write, data_read, push, pop;
  logic [WIDTH-1:0] sr0_out, sr1_out, sr127_out;
  logic [15:0]      ds_size;
  logic             stack_overflow;
`ifdef DS_UNDERFLOW_EN
  logic             stack_underflow;
`endif

  int checks = 0;
  int errors = 0;

  data_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .async_reset    (async_reset),
    .sr0_in         (sr0_in),
    .sr1_in         (sr1_in),
    .sr127_in       (sr127_in),
    .sr1_overwrite  (sr1_overwrite),
    .data_write     (data_write),
    .data_read      (data_read),
    .push           (push),
    .pop            (pop),
    .sr0_out        (sr0_out),
    .sr1_out        (sr1_out),
    .sr127_out      (sr127_out),
    .ds_size        (ds_size),
`ifdef DS_UNDERFLOW_EN
    .stack_underflow(stack_underflow),
`endif
    .stack_overflow (stack_overflow)
  );

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Apply one command for one edge, then sample 1ns after that edge.
  task automatic cycle(input logic p, input logic q, input logic dw,
                       input logic ov, input logic [WIDTH-1:0] d0,
                       input logic [WIDTH-1:0] d1, input logic [WIDTH-1:0] dfill);
    push = p; pop = q; data_write = dw; sr1_overwrite = ov;
    sr0_in = d0; sr1_in = d1; sr127_in = dfill;
    data_read = 1'b1;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; data_write = 1'b0; sr1_overwrite = 1'b0;
    data_read = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    async_reset = 1'b0;
    #3;
    async_reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    push = 0; pop = 0; data_write = 0; sr1_overwrite = 0; data_read = 0;
    sr0_in = '0; sr1_in = '0; sr127_in = '0;
    async_reset = 1'b0;
    #100;
    checks++; if (sr0_out !== 16'h0) begin errors++; $display("FAIL reset_sr0 got %h exp 0000", sr0_out); end
    checks++; if (sr1_out !== 16'h0) begin errors++; $display("FAIL reset_sr1 got %h exp 0000", sr1_out); end
    checks++; if (sr127_out !== 16'h0) begin errors++; $display("FAIL reset_sr127 got %h exp 0000", sr127_out); end
    checks++; if (ds_size !== 16'd0) begin errors++; $display("FAIL reset_size got %0d exp 0", ds_size); end
    checks++; if (stack_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", stack_overflow); end
`ifdef DS_UNDERFLOW_EN
    checks++; if (stack_underflow !== 1'b0) begin errors++; $display("FAIL reset_unf got %b exp 0", stack_underflow); end
`endif
    #3;
    async_reset = 1'b1;
  endtask

  task automatic test_push20();
    for (int i = 0; i < 20; i++) cycle(1, 0, 1, 0, 16'(i), 16'h0, 16'h0);
    checks++; if (sr0_out !== 16'd19) begin errors++; $display("FAIL push20_sr0 got %0d exp 19", sr0_out); end
    checks++; if (sr1_out !== 16'd18) begin errors++; $display("FAIL push20_sr1 got %0d exp 18", sr1_out); end
    checks++; if (ds_size !== 16'd20) begin errors++; $display("FAIL push20_size got %0d exp 20", ds_size); end
    checks++; if (stack_overflow !== 1'b0) begin errors++; $display("FAIL push20_ovf got %b exp 0", stack_overflow); end
  endtask

  task automatic test_overwrite_top();
    cycle(1, 0, 1, 0, 16'd5, 16'h0, 16'h0);
    checks++; if (ds_size !== 16'd21) begin errors++; $display("FAIL ovw_push_size got %0d exp 21", ds_size); end
    cycle(0, 0, 1, 0, 16'd10, 16'h0, 16'h0);
    checks++; if (sr0_out !== 16'd10) begin errors++; $display("FAIL ovw_sr0 got %0d exp 10", sr0_out); end
    checks++; if (sr1_out !== 16'd19) begin errors++; $display("FAIL ovw_sr1 got %0d exp 19", sr1_out); end
    checks++; if (ds_size !== 16'd21) begin errors++; $display("FAIL ovw_size got %0d exp 21", ds_size); end
    // An idle cycle with no write holds the stack.
    cycle(0, 0, 0, 0, 16'd77, 16'h0, 16'h0);
    checks++; if (sr0_out !== 16'd10) begin errors++; $display("FAIL hold_sr0 got %0d exp 10", sr0_out); end
  endtask

  task automatic test_sr1_overwrite();
    cycle(1, 0, 1, 0, 16'd1, 16'h0, 16'h0);          // [1,10,19,..] size 22
    cycle(1, 0, 1, 1, 16'd2, 16'd99, 16'h0);         // [2,99,10,19,..] size 23
    checks++; if (sr0_out !== 16'd2) begin errors++; $display("FAIL s1ov_sr0 got %0d exp 2", sr0_out); end
    checks++; if (sr1_out !== 16'd99) begin errors++; $display("FAIL s1ov_sr1 got %0d exp 99", sr1_out); end
    checks++; if (ds_size !== 16'd23) begin errors++; $display("FAIL s1ov_size got %0d exp 23", ds_size); end
    // Pop to expose sr2 at sr1.
    cycle(0, 1, 0, 0, 16'h0, 16'h0, 16'h0);
    checks++; if (sr0_out !== 16'd99) begin errors++; $display("FAIL s1ov_pop_sr0 got %0d exp 99", sr0_out); end
    checks++; if (sr1_out !== 16'd10) begin errors++; $display("FAIL s1ov_sr2 got %0d exp 10", sr1_out); end
    checks++; if (ds_size !== 16'd22) begin errors++; $display("FAIL s1ov_pop_size got %0d exp 22", ds_size); end
    // The override also applies on a hold cycle.
    cycle(0, 0, 0, 1, 16'h0, 16'h1234, 16'h0);
    checks++; if (sr1_out !== 16'h1234) begin errors++; $display("FAIL s1ov_hold_sr1 got %h exp 1234", sr1_out); end
    checks++; if (sr0_out !== 16'd99) begin errors++; $display("FAIL s1ov_hold_sr0 got %0d exp 99", sr0_out); end
  endtask

  task automatic test_pop_fill();
    do_reset();
    cycle(1, 0, 1, 0, 16'h000A, 16'h0, 16'h0);
    cycle(1, 0, 1, 0, 16'h000B, 16'h0, 16'h0);
    cycle(1, 0, 1, 0, 16'h000C, 16'h0, 16'h0);       // [C,B,A]
    // data_write is set on this pop and must be ignored.
    cycle(0, 1, 1, 0, 16'hFFFF, 16'h0, 16'd7);
    checks++; if (sr0_out !== 16'h000B) begin errors++; $display("FAIL pop1_sr0 got %h exp 000b", sr0_out); end
    checks++; if (sr1_out !== 16'h000A) begin errors++; $display("FAIL pop1_sr1 got %h exp 000a", sr1_out); end
    checks++; if (sr127_out !== 16'd7) begin errors++; $display("FAIL pop1_sr127 got %0d exp 7", sr127_out); end
    checks++; if (ds_size !== 16'd2) begin errors++; $display("FAIL pop1_size got %0d exp 2", ds_size); end
    cycle(0, 1, 0, 0, 16'h0, 16'h0, 16'd7);
    checks++; if (sr0_out !== 16'h000A) begin errors++; $display("FAIL pop2_sr0 got %h exp 000a", sr0_out); end
    cycle(0, 1, 0, 0, 16'h0, 16'h0, 16'd7);
    checks++; if (sr0_out !== 16'h0) begin errors++; $display("FAIL pop3_sr0 got %h exp 0000", sr0_out); end
    checks++; if (ds_size !== 16'd0) begin errors++; $display("FAIL pop3_size got %0d exp 0", ds_size); end
`ifdef DS_UNDERFLOW_EN
    checks++; if (stack_underflow !== 1'b0) begin errors++; $display("FAIL pop3_unf got %b exp 0", stack_underflow); end
`endif
    // A pop on empty performs no shift. A shift would move 7 into sr126 and
    // then leave sr127 at the new fill value 9.
    cycle(0, 1, 0, 0, 16'h0, 16'h0, 16'd9);
    checks++; if (ds_size !== 16'd0) begin errors++; $display("FAIL pop4_size got %0d exp 0", ds_size); end
    checks++; if (sr127_out !== 16'd7) begin errors++; $display("FAIL pop4_sr127 got %0d exp 7", sr127_out); end
    checks++; if (sr0_out !== 16'h0) begin errors++; $display("FAIL pop4_sr0 got %h exp 0000", sr0_out); end
`ifdef DS_UNDERFLOW_EN
    checks++; if (stack_underflow !== 1'b1) begin errors++; $display("FAIL pop4_unf got %b exp 1", stack_underflow); end
`endif
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 129; i++) cycle(1, 0, 1, 0, 16'(i), 16'h0, 16'h0);
    checks++; if (ds_size !== 16'd128) begin errors++; $display("FAIL ovf_size got %0d exp 128", ds_size); end
    checks++; if (stack_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", stack_overflow); end
    checks++; if (sr0_out !== 16'd129) begin errors++; $display("FAIL ovf_sr0 got %0d exp 129", sr0_out); end
    checks++; if (sr1_out !== 16'd128) begin errors++; $display("FAIL ovf_sr1 got %0d exp 128", sr1_out); end
    checks++; if (sr127_out !== 16'd2) begin errors++; $display("FAIL ovf_sr127 got %0d exp 2", sr127_out); end
    cycle(0, 1, 0, 0, 16'h0, 16'h0, 16'h0055);
    checks++; if (ds_size !== 16'd127) begin errors++; $display("FAIL ovf_pop_size got %0d exp 127", ds_size); end
    checks++; if (stack_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", stack_overflow); end
    checks++; if (sr0_out !== 16'd128) begin errors++; $display("FAIL ovf_pop_sr0 got %0d exp 128", sr0_out); end
    checks++; if (sr127_out !== 16'h0055) begin errors++; $display("FAIL ovf_pop_sr127 got %h exp 0055", sr127_out); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 1; i <= 5; i++) cycle(1, 0, 1, 0, 16'(i), 16'h0, 16'h0); // [5,4,3,2,1]
    cycle(1, 1, 1, 0, 16'hABCD, 16'h0, 16'h0);
    checks++; if (sr0_out !== 16'hABCD) begin errors++; $display("FAIL pp_sr0 got %h exp abcd", sr0_out); end
    checks++; if (sr1_out !== 16'd4) begin errors++; $display("FAIL pp_sr1 got %0d exp 4", sr1_out); end
    checks++; if (ds_size !== 16'd5) begin errors++; $display("FAIL pp_size got %0d exp 5", ds_size); end
    // A push without data_write duplicates the top.
    cycle(1, 0, 0, 0, 16'h1111, 16'h0, 16'h0);
    checks++; if (sr0_out !== 16'hABCD) begin errors++; $display("FAIL dup_sr0 got %h exp abcd", sr0_out); end
    checks++; if (sr1_out !== 16'hABCD) begin errors++; $display("FAIL dup_sr1 got %h exp abcd", sr1_out); end
    checks++; if (ds_size !== 16'd6) begin errors++; $display("FAIL dup_size got %0d exp 6", ds_size); end
  endtask

  task automatic test_async_reset();
    // Assert reset between edges, then sample before the next edge.
    #2;
    async_reset = 1'b0;
    #1;
    checks++; if (sr0_out !== 16'h0) begin errors++; $display("FAIL areset_sr0 got %h exp 0000", sr0_out); end
    checks++; if (sr1_out !== 16'h0) begin errors++; $display("FAIL areset_sr1 got %h exp 0000", sr1_out); end
    checks++; if (ds_size !== 16'd0) begin errors++; $display("FAIL areset_size got %0d exp 0", ds_size); end
    checks++; if (stack_overflow !== 1'b0) begin errors++; $display("FAIL areset_ovf got %b exp 0", stack_overflow); end
    #2;
    async_reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_push20();
    test_overwrite_top();
    test_sr1_overwrite();
    test_pop_fill();
    test_overflow();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
